// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth significand multiplier, one digit per cycle.
// Define BOOTH_MUL_SEQ_EARLY_TERM_EN to finish as soon as the remaining Booth digits are all zero.
module booth_mul_seq #(
   parameter  int DWIDTH = 11,
   localparam int NGRP   = (DWIDTH + 2) / 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DWIDTH-1:0]     in_a,
   input  logic [DWIDTH-1:0]     in_b,
   input  logic                  flush,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2*DWIDTH-1:0]   out_p
);
   localparam int MW = 2 * NGRP + 1;
   localparam int AW = 2 * DWIDTH + 2;
   localparam int PW = DWIDTH + 2;
   localparam int CW = $clog2(NGRP) + 1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t            state, state_nx;
   logic [DWIDTH-1:0] a_q;
   logic [MW-1:0]     m_q;
   logic [AW-1:0]     acc_q, acc_nx, pp_ext;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        dig;
   logic              neg, one, two, last_dig, accept;
   logic [PW-1:0]     mag, pp;
   assign dig    = m_q[2:0];
   assign neg    = dig[2] & ~(dig[1] & dig[0]);
   assign one    = dig[1] ^ dig[0];
   assign two    = (dig == 3'b011) | (dig == 3'b100);
   assign mag    = two ? {1'b0, a_q, 1'b0} : one ? {2'b00, a_q} : '0;
   assign pp     = neg ? ~mag : mag;
   assign pp_ext = {{(AW-PW){pp[PW-1]}}, pp};
   // the sign bit doubles as carry-in, completing the two's complement of negative digits
   assign acc_nx = acc_q + (pp_ext << {cnt_q, 1'b0}) + ({{(AW-1){1'b0}}, neg} << {cnt_q, 1'b0});
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
   assign last_dig = (cnt_q == CW'(NGRP - 1)) | (m_q[MW-1:2] == '0);
`else
   assign last_dig = cnt_q == CW'(NGRP - 1);
`endif
   assign accept    = (state == IDLE) & in_valid & ~flush;
   assign in_ready  = state == IDLE;
   assign busy      = state == BUSY;
   assign out_valid = state == DONE;
   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else if (state == IDLE && in_valid) state_nx = BUSY;
      else if (state == BUSY && last_dig) state_nx = DONE;
      else if (state == DONE && out_ready) state_nx = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_q   <= '0;
         m_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         out_p <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_q   <= in_a;
            m_q   <= MW'({in_b, 1'b0});
            acc_q <= '0;
            cnt_q <= '0;
         end else if (state == BUSY && !flush) begin
            acc_q <= acc_nx;
            m_q   <= m_q >> 2;
            cnt_q <= cnt_q + CW'(1);
            if (last_dig) out_p <= acc_nx[2*DWIDTH-1:0];
         end
      end
   end
   // an unsigned product must leave the accumulator sign bits clear
   always_ff @(posedge clk) begin
      if (rst_n && state == BUSY && last_dig) assert (acc_nx[AW-1:2*DWIDTH] == '0);
   end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed and random checks of booth_mul_seq at DWIDTH=11.
module tb_booth_mul_seq;
   logic        clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
   logic [10:0] in_a = 0, in_b = 0;
   logic        in_ready, busy, out_valid;
   logic [21:0] out_p, last_p;
   int          checks = 0, errors = 0;
   booth_mul_seq #(.DWIDTH(11)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .flush(flush), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic int exp_lat(input logic [10:0] b);
`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
      logic [12:0] m;
      logic [2:0]  d;
      int          l;
      m = {1'b0, b, 1'b0};
      l = 1;
      for (int i = 0; i < 6; i++) begin
         d = m[2*i +: 3];
         if (d != 3'b000 && d != 3'b111) l = i + 1;
      end
      return l;
`else
      return 6;
`endif
   endfunction
   task automatic start(input logic [10:0] a, input logic [10:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      chk("ready_wait", in_ready, 1);
      in_a = a;
      in_b = b;
      in_valid = 1;
      step();
      in_valid = 0;
   endtask
   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         step();
         lat++;
      end while (!out_valid && lat < 50);
   endtask
   task automatic mul(input logic [10:0] a, input logic [10:0] b, input int stall);
      int          lat;
      logic [21:0] exp;
      exp = 22'(a) * 22'(b);
      out_ready = (stall == 0);
      start(a, b);
      wait_valid(lat);
      chk("latency", lat, exp_lat(b));
      for (int i = 0; i < stall; i++) begin
         chk("stall_hold", {out_valid, in_ready, out_p}, {1'b1, 1'b0, exp});
         step();
      end
      out_ready = 1;
      chk("product", {out_valid, out_p}, {1'b1, exp});
      last_p = exp;
      step();
      out_ready = 0;
      chk("drained", {in_ready, out_valid}, 2'b10);
   endtask
   initial begin
      int lat;
      int seen;
      #2;
      chk("rst_state", {in_ready, busy, out_valid, out_p}, {3'b100, 22'h0});
      step();
      rst_n = 1;
      step();
      chk("post_rst", {in_ready, busy, out_valid}, 3'b100);
      mul(11'h7FF, 11'h7FF, 0);
      chk("max_const", out_p, 22'h3FF001);
      mul(11'h001, 11'h001, 0);
      chk("one_const", out_p, 22'h000001);
      mul(11'h400, 11'h400, 5);
      chk("pow2_const", out_p, 22'h100000);
      mul(11'h555, 11'h2AA, 0);
      // flush on the third BUSY cycle
      start(11'h123, 11'h456);
      chk("busy_hi", {busy, in_ready}, 2'b10);
      step();
      step();
      flush = 1;
      step();
      flush = 0;
      chk("flush_idle", {in_ready, busy, out_valid}, 3'b100);
      chk("flush_keep_p", out_p, last_p);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen++;
         step();
      end
      chk("flush_no_valid", seen, 0);
      mul(11'h003, 11'h005, 0);
      chk("small_const", out_p, 22'h00000F);
      // flush beats a simultaneous accept in IDLE
      in_a = 11'h0AB;
      in_b = 11'h0CD;
      in_valid = 1;
      flush = 1;
      step();
      in_valid = 0;
      flush = 0;
      chk("flush_idle_acc", {in_ready, busy}, 2'b10);
      step();
      chk("flush_idle_acc2", {in_ready, busy, out_valid}, 3'b100);
      // async reset while a product is waiting
      out_ready = 0;
      start(11'h7FF, 11'h7FF);
      wait_valid(lat);
      chk("rst_pre_valid", out_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("rst_async", {in_ready, busy, out_valid, out_p}, {3'b100, 22'h0});
      #2 rst_n = 1;
      step();
      chk("rst_release", {in_ready, out_valid}, 2'b10);
      for (int i = 0; i < 500; i++) mul(11'($urandom), 11'($urandom), $urandom_range(0, 3));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
